dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 181 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the multi-cycle data-memory
// responder.
//   state_t     - responder FSM states
//   dmem_req_t  - captured request (op, full address, store data)
//   ADDR_W_DEF  - default word-address width
//   DATA_W_DEF  - default data width
//   DATA_W_MAX  - widest data word the capture struct can hold
package dmem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DATA_W_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // The struct lives in the package, so its fields are sized for the
    // widest legal configuration. The responder zero-extends store data
    // into it and uses only the low ADDR_W / DATA_W bits.
    typedef struct packed {
        logic                  op_write;
        logic [31:0]           addr;
        logic [DATA_W_MAX-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word storage.
//   clk    - clock
//   rst    - synchronous clear of every word and of rd
//   we     - write strobe: mem[waddr] <= wdata
//   re     - read strobe:  rd <= mem[raddr]; rd holds otherwise
//   waddr  - write word address
//   raddr  - read word address
//   wdata  - write data
//   rd     - registered read data
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
        end else if (re) begin
            rd <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Stalls the pipeline for WAIT_CYCLES cycles per access and commits the
// captured request on the edge that enters DONE.
//   clk        - clock
//   rst        - synchronous reset, active-high (also clears the array)
//   mem_read   - read request
//   mem_write  - write request (wins when both strobes are high)
//   addr       - word address; only addr[ADDR_W-1:0] indexes the array
//   wdata      - store data
//   rdata      - registered read data, held until the next read commits
//   mem_stall  - pipeline freeze request (combinational)
//   mem_err    - sticky range/strobe error, only with DMEM_RANGE_CHK_EN
// Optional feature macro: DMEM_RANGE_CHK_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; a request is accepted and captured here
// WAIT  | wait states; cnt counts down to 0, inputs ignored
// DONE  | access committed on entry; stall released; back to IDLE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
`ifdef DMEM_RANGE_CHK_EN
    output logic              mem_stall,
    output logic              mem_err
`else
    output logic              mem_stall
`endif
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 31) begin : g_bad_addr
        $error("dmem_responder: ADDR_W must be in 1..31");
    end
    if (DATA_W < 1 || DATA_W > DATA_W_MAX) begin : g_bad_data
        $error("dmem_responder: DATA_W exceeds capture width");
    end

    // First WAIT cycle already counts as one wait state, hence the -2.
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q;
    logic        req;
    logic        accept;
    logic        commit;

    logic              commit_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_wdata;
    logic [DATA_W-1:0] captured_wdata;

    // Request is masked during reset so the reset state shows no stall.
    assign req = (mem_read | mem_write) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    accept    = 1'b1;
                    if (WAIT_CYCLES == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    commit  = ~rst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.op_write <= mem_write;
            req_q.addr     <= addr;
            req_q.wdata    <= DATA_W_MAX'(wdata);
        end
    end

    assign captured_wdata = req_q.wdata[DATA_W-1:0];

    // With a single wait state the commit edge is also the accept edge, so
    // the live inputs are committed directly instead of the capture regs.
    always_comb begin
        if (state_q == IDLE) begin
            commit_write = mem_write;
            commit_addr  = addr[ADDR_W-1:0];
            commit_wdata = wdata;
        end else begin
            commit_write = req_q.op_write;
            commit_addr  = req_q.addr[ADDR_W-1:0];
            commit_wdata = captured_wdata;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit & commit_write),
        .re    (commit & ~commit_write),
        .waddr (commit_addr),
        .raddr (commit_addr),
        .wdata (commit_wdata),
        .rd    (rdata)
    );

    // Upper address bits and the spare capture bits are intentionally
    // dropped (address wrap, narrower DATA_W).
    logic unused_bits;
    assign unused_bits = ^{addr, req_q};

`ifdef DMEM_RANGE_CHK_EN
    logic err_q;
    logic err_hit;

    assign err_hit = (|addr[31:ADDR_W]) | (mem_read & mem_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic        mem_read  [NI];
    logic        mem_write [NI];
    logic [31:0] addr      [NI];
    logic [31:0] wdata     [NI];
    logic [31:0] rdata     [NI];
    logic        mem_stall [NI];
    logic        mem_err   [NI];

    int          errors;
    int          checks;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd [NI];
    logic        exp_err [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .ADDR_W      (10),
            .DATA_W      (32),
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rdata     (rdata[g]),
`ifdef DMEM_RANGE_CHK_EN
            .mem_stall (mem_stall[g]),
            .mem_err   (mem_err[g])
`else
            .mem_stall (mem_stall[g])
`endif
        );
`ifndef DMEM_RANGE_CHK_EN
        assign mem_err[g] = 1'b0;
`endif
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic int key_of(input int k, input logic [31:0] a);
        return k * 4096 + int'(a[9:0]);
    endfunction

    task automatic check_err(input int k, input string tag);
`ifdef DMEM_RANGE_CHK_EN
        checks++;
        if (mem_err[k] !== exp_err[k]) begin
            errors++;
            $display("FAIL %s mem_err k=%0d got %b want %b", tag, k, mem_err[k], exp_err[k]);
        end
`endif
    endtask

    // Starts at a negedge with all of instance k's strobes idle; returns at
    // the negedge after DONE with strobes dropped, so a following call is
    // back-to-back.
    task automatic access(input int k, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit scramble);
        int wc;
        wc = wc_of(k);
        mem_read[k]  = rd;
        mem_write[k] = wr;
        addr[k]      = a;
        wdata[k]     = wd;
        if (wr) model[key_of(k, a)] = wd;
        else if (rd) exp_q.push_back(model.exists(key_of(k, a)) ? model[key_of(k, a)] : 32'h0);
        if ((rd && wr) || a[31:10] != 0) exp_err[k] = 1'b1;
        for (int c = 0; c <= wc; c++) begin
            if (c > 0) @(negedge clk);
            if (scramble && c >= 1) begin
                addr[k]  = a ^ 32'h5;
                wdata[k] = ~wd;
            end
            #1;
            checks++;
            if (mem_stall[k] !== (c < wc)) begin
                errors++;
                $display("FAIL stall k=%0d addr=%0h cyc=%0d got %b want %b",
                         k, a, c, mem_stall[k], (c < wc));
            end
        end
        if (rd && !wr) last_rd[k] = exp_q.pop_front();
        checks++;
        if (rdata[k] !== last_rd[k]) begin
            errors++;
            $display("FAIL rdata k=%0d addr=%0h got %h want %h", k, a, rdata[k], last_rd[k]);
        end
        check_err(k, "access");
        @(negedge clk);
        mem_read[k]  = 1'b0;
        mem_write[k] = 1'b0;
    endtask

    task automatic check_idle(input int k, input string tag);
        #1;
        checks++;
        if (mem_stall[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s idle stall k=%0d got %b want 0", tag, k, mem_stall[k]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        exp_q.delete();
        for (int k = 0; k < NI; k++) begin
            last_rd[k] = '0;
            exp_err[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        // Request held high in IDLE while rst is high must not stall.
        rst = 1'b1;
        mem_read[1] = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (mem_stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_masked_stall got %b want 0", mem_stall[1]);
        end
        mem_read[1] = 1'b0;
        do_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (rdata[k] !== 32'h0 || mem_stall[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state k=%0d rdata=%h stall=%b want 0/0", k, rdata[k], mem_stall[k]);
            end
            check_err(k, "reset");
        end
    endtask

    task automatic test_basic_read();
        access(0, 1, 0, 32'd5, 32'h0, 0);
        check_idle(0, "basic");
    endtask

    task automatic test_write_read();
        access(0, 0, 1, 32'd3, 32'hDEADBEEF, 0);
        @(negedge clk);
        access(0, 1, 0, 32'd3, 32'h0, 0);
    endtask

    task automatic test_write_wins();
        access(0, 1, 1, 32'd7, 32'h12, 0);
        access(0, 1, 0, 32'd7, 32'h0, 0);
    endtask

    task automatic test_wrap();
        do_reset();
        check_err(0, "wrap_pre");
        access(0, 0, 1, 32'h400, 32'hA5, 0);
        access(0, 1, 0, 32'h0, 32'h0, 0);
        repeat (3) @(negedge clk);
        check_err(0, "wrap_sticky");
    endtask

    task automatic test_reset_abort();
        mem_write[0] = 1'b1;
        addr[0]      = 32'd9;
        wdata[0]     = 32'h55;
        #1;
        checks++;
        if (mem_stall[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept stall got %b want 1", mem_stall[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_write[0] = 1'b0;
        model.delete();
        for (int k = 0; k < NI; k++) begin
            last_rd[k] = '0;
            exp_err[k] = 1'b0;
        end
        check_idle(0, "abort");
        @(negedge clk);
        access(0, 1, 0, 32'd9, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        access(0, 0, 1, 32'd20, 32'h0BAD_CAFE, 0);
        access(0, 1, 0, 32'd20, 32'h0, 0);
        access(0, 0, 1, 32'd21, 32'h1234_5678, 0);
        access(0, 1, 0, 32'd21, 32'h0, 0);
        check_idle(0, "b2b");
    endtask

    task automatic test_capture();
        for (int k = 0; k < NI; k++) begin
            access(k, 0, 1, 32'd40 + 32'(k), 32'hC0DE_0000 + 32'(k), 1);
            access(k, 1, 0, 32'd40 + 32'(k), 32'h0, 1);
            access(k, 1, 0, (32'd40 + 32'(k)) ^ 32'h5, 32'h0, 0);
            check_idle(k, "capture");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        for (int k = 0; k < NI; k++) begin
            mem_read[k]  = 1'b0;
            mem_write[k] = 1'b0;
            addr[k]      = '0;
            wdata[k]     = '0;
            last_rd[k]   = '0;
            exp_err[k]   = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic_read();
        test_write_read();
        test_write_wins();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        test_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
